outpass4_ser_frame_config: RTL and testbench

Fabric-to-pad output BEL, the outbound counterpart of the 4-channel input pass BEL: takes four fabric signals and drives four external pins. In parallel mode each channel is independently combinational or registered. In serial mode the four inputs form a 4-bit word shifted out on one pin with framing strobes and a LOAD/BUSY handshake toward the fabric. Sits in IO tiles beside the input pass BELs, configured through frame config bits.

---
 rtl/outpass4_ser_frame_config.sv | 120 ++++++++++++
 tb/tb_outpass4_ser_frame_config.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/outpass4_ser_frame_config.sv
// Four-channel fabric-to-pad output BEL: per-channel combinational/registered pass,
// plus an optional framed 4-bit serializer enabled by the OUTPASS4_SER_EN macro.
module outpass4_ser_frame_config #(
    parameter int NoConfigBits = 6
) (
    input  logic                    UserCLK,
    input  logic                    RST,
    input  logic                    I0,
    input  logic                    I1,
    input  logic                    I2,
    input  logic                    I3,
    input  logic                    LOAD,
    output logic                    BUSY,
    output logic                    O0,
    output logic                    O1,
    output logic                    O2,
    output logic                    O3,
    input  logic [NoConfigBits-1:0] ConfigBits
);

    logic [3:0] w_in;
    logic [3:0] r_q;
    logic [3:0] w_par;

    assign w_in = {I3, I2, I1, I0};

    always_ff @(posedge UserCLK) begin
        if (RST) begin
            r_q <= 4'b0000;
        end else begin
            r_q <= w_in;
        end
    end

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            w_par[n] = ConfigBits[n] ? r_q[n] : w_in[n];
        end
    end

`ifdef OUTPASS4_SER_EN
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [1:0] r_cnt,   w_cnt_nxt;
    logic [3:0] r_sr,    w_sr_nxt;
    // serial output registers: {first-bit marker, frame valid, data}
    logic [2:0] r_so,    w_so_nxt;
    logic       w_ser;
    logic       w_busy;
    logic       w_accept;
    logic [3:0] w_word;

    assign w_ser    = ConfigBits[4];
    assign w_busy   = w_ser & (r_state == S_SHIFT) & (r_cnt != 2'd3);
    assign w_accept = w_ser & LOAD & ~w_busy;
    assign w_word   = ConfigBits[5] ? {I0, I1, I2, I3} : w_in;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sr_nxt    = r_sr;
        w_so_nxt    = 3'b000;
        if (!w_ser) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 2'd0;
        end else if (w_accept) begin
            w_state_nxt = S_SHIFT;
            w_cnt_nxt   = 2'd0;
            w_sr_nxt    = w_word;
            w_so_nxt    = {1'b1, 1'b1, w_word[0]};
        end else if (r_state == S_SHIFT) begin
            if (r_cnt == 2'd3) begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 2'd0;
            end else begin
                w_cnt_nxt = r_cnt + 2'd1;
                w_sr_nxt  = r_sr >> 1;
                w_so_nxt  = {1'b0, 1'b1, r_sr[1]};
            end
        end
    end

    always_ff @(posedge UserCLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
            r_sr    <= 4'b0000;
            r_so    <= 3'b000;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sr    <= w_sr_nxt;
            r_so    <= w_so_nxt;
        end
    end

    always_comb begin
        if (w_ser) begin
            {O3, O2, O1, O0} = {1'b0, r_so};
        end else begin
            {O3, O2, O1, O0} = w_par;
        end
        BUSY = w_busy;
    end
`else
    // serial controls are part of the fixed port/bitstream layout but have no effect here
    logic w_unused_ser;
    assign w_unused_ser = ^{LOAD, ConfigBits[NoConfigBits-1:4]};

    always_comb begin
        {O3, O2, O1, O0} = w_par;
        BUSY = 1'b0;
    end
`endif

endmodule

// File: tb/tb_outpass4_ser_frame_config.sv
// Scoreboard bench for outpass4_ser_frame_config: a cycle-level behavioural model
// pushes expected pin/BUSY values, a negedge monitor pops and compares them.
module tb_outpass4_ser_frame_config;

`ifdef OUTPASS4_SER_EN
    localparam bit SER_EN = 1'b1;
`else
    localparam bit SER_EN = 1'b0;
`endif

    logic       UserCLK = 1'b0;
    logic       RST;
    logic       I0, I1, I2, I3;
    logic       LOAD;
    logic       BUSY;
    logic       O0, O1, O2, O3;
    logic [5:0] ConfigBits;

    outpass4_ser_frame_config #(.NoConfigBits(6)) dut (
        .UserCLK   (UserCLK),
        .RST       (RST),
        .I0        (I0),
        .I1        (I1),
        .I2        (I2),
        .I3        (I3),
        .LOAD      (LOAD),
        .BUSY      (BUSY),
        .O0        (O0),
        .O1        (O1),
        .O2        (O2),
        .O3        (O3),
        .ConfigBits(ConfigBits)
    );

    always #5 UserCLK = ~UserCLK;

    typedef struct {
        logic [3:0] o;
        logic       busy;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    // Reference model: parallel flops plus the schedule of serial pin values still to appear.
    logic [3:0] m_q;
    logic [2:0] m_cur;      // {first, valid, data} currently on O2..O0
    logic [2:0] m_pend[$];  // serial pin values for upcoming cycles

    task automatic step(input logic rst, input logic [5:0] cfg, input logic [3:0] i, input logic ld);
        exp_t       e;
        logic       ser;
        logic [3:0] word;
        RST        = rst;
        ConfigBits = cfg;
        {I3, I2, I1, I0} = i;
        LOAD       = ld;
        ser = SER_EN && cfg[4];
        for (int n = 0; n < 4; n++) e.o[n] = cfg[n] ? m_q[n] : i[n];
        if (ser) e.o = {1'b0, m_cur};
        e.busy = ser && (m_pend.size() > 0);
        e.cyc  = cyc;
        exp_q.push_back(e);
        @(posedge UserCLK);
        if (rst) begin
            m_q   = 4'b0000;
            m_cur = 3'b000;
            m_pend.delete();
        end else begin
            m_q = i;
            if (!ser) begin
                m_cur = 3'b000;
                m_pend.delete();
            end else if (ld && m_pend.size() == 0) begin
                word  = cfg[5] ? {i[0], i[1], i[2], i[3]} : i;
                m_cur = {2'b11, word[0]};
                m_pend.delete();
                for (int k = 1; k < 4; k++) m_pend.push_back({2'b01, word[k]});
            end else if (m_pend.size() > 0) begin
                m_cur = m_pend.pop_front();
            end else begin
                m_cur = 3'b000;
            end
        end
        cyc++;
        #1;
    endtask

    always @(negedge UserCLK) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({O3, O2, O1, O0} !== e.o) begin
                errors++;
                $display("FAIL pins cyc=%0d got=%b exp=%b", e.cyc, {O3, O2, O1, O0}, e.o);
            end
            checks++;
            if (BUSY !== e.busy) begin
                errors++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", e.cyc, BUSY, e.busy);
            end
        end
    end

    initial begin
        logic [5:0] rcfg;
        m_q   = 4'b0000;
        m_cur = 3'b000;
        RST = 1'b1; ConfigBits = 6'b0; {I3, I2, I1, I0} = 4'b0; LOAD = 1'b0;
        @(posedge UserCLK);
        #1;

        // reset state, then parallel mixed registered/combinational
        step(1'b1, 6'b000101, 4'b0110, 1'b1);
        step(1'b0, 6'b000101, 4'b1111, 1'b0);
        step(1'b0, 6'b000101, 4'b0000, 1'b0);
        step(1'b0, 6'b000101, 4'b0000, 1'b0);
        step(1'b0, 6'b001111, 4'b1001, 1'b1);
        step(1'b0, 6'b001111, 4'b0110, 1'b0);

        // serial LSB-first, then MSB-first, word 1011
        step(1'b0, 6'b010000, 4'b1011, 1'b1);
        repeat (6) step(1'b0, 6'b010000, 4'b0000, 1'b0);
        step(1'b0, 6'b110000, 4'b1011, 1'b1);
        repeat (6) step(1'b0, 6'b110000, 4'b0000, 1'b0);

        // back-to-back: LOAD held while A then 5 presented
        for (int c = 0; c < 10; c++)
            step(1'b0, 6'b010000, (c < 4) ? 4'hA : 4'h5, (c < 5) ? 1'b1 : 1'b0);

        // reset on bit cycle 2, LOAD blocked during reset, fresh frame afterwards
        step(1'b0, 6'b010000, 4'b1101, 1'b1);
        step(1'b0, 6'b010000, 4'b0000, 1'b0);
        step(1'b1, 6'b010000, 4'b0111, 1'b1);
        step(1'b0, 6'b010000, 4'b0111, 1'b1);
        repeat (5) step(1'b0, 6'b010000, 4'b0000, 1'b0);

        // serial mode dropped mid-frame, then re-enabled
        step(1'b0, 6'b010000, 4'b1111, 1'b1);
        step(1'b0, 6'b000011, 4'b1010, 1'b1);
        step(1'b0, 6'b010000, 4'b0000, 1'b0);
        step(1'b0, 6'b010000, 4'b0000, 1'b0);

        // randomized blocks of configuration, data, LOAD and occasional reset
        for (int b = 0; b < 12; b++) begin
            rcfg = 6'($urandom);
            for (int c = 0; c < 40; c++)
                step(($urandom_range(0, 49) == 0), rcfg, 4'($urandom), 1'($urandom));
        end

        for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(negedge UserCLK);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain left=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
